// File: rtl/raster_stamp_serializer.sv
// ---------------------------------------------------------------------------
// raster_stamp_serializer
//
// Purpose:
//   Takes one batch of OUTPUT_QUADS raster stamps per input handshake and
//   emits only the covered stamps (non-zero coverage mask), one per cycle and
//   in ascending slot order, on a single-stamp output stream. A batch with no
//   covered stamp is accepted in one cycle and dropped. Also provides a busy
//   flag and two wrap-around performance counters.
//
// Handshake:
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. Once valid_out is raised it stays high, with stamp_out unchanged,
//   until the stamp is taken. ready_in may depend combinationally on
//   ready_out, so that a new batch can load on the same edge that the last
//   pending stamp leaves.
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous, active-low reset
//   valid_in            input batch valid
//   stamps_in           input batch, slot i = stamps_in[i]
//   ready_in            batch accepted when valid_in && ready_in
//   valid_out           output stamp valid
//   stamp_out           current output stamp (0 when nothing is pending)
//   ready_out           output stamp consumed when valid_out && ready_out
//   busy_out            stamps pending or a batch offered at the input
//   perf_stamps_out     count of emitted stamps (wraps)
//   perf_empty_batches  count of accepted batches with no covered stamp (wraps)
// ---------------------------------------------------------------------------

package raster_stamp_pkg;

    typedef struct packed {
        logic [7:0] prim_id;
        logic [9:0] y;
        logic [9:0] x;
        logic [3:0] mask;
    } raster_stamp_t;

endpackage

module raster_stamp_serializer
    import raster_stamp_pkg::*;
#(
    parameter int OUTPUT_QUADS  = 4,
    parameter int PERF_CTR_BITS = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  valid_in,
    input  raster_stamp_t [OUTPUT_QUADS-1:0]      stamps_in,
    output logic                                  ready_in,
    output logic                                  valid_out,
    output raster_stamp_t                         stamp_out,
    input  logic                                  ready_out,
    output logic                                  busy_out,
    output logic [PERF_CTR_BITS-1:0]              perf_stamps_out,
    output logic [PERF_CTR_BITS-1:0]              perf_empty_batches
);

    raster_stamp_t [OUTPUT_QUADS-1:0] batch_q;
    logic [OUTPUT_QUADS-1:0]          pend_q;
    logic [OUTPUT_QUADS-1:0]          pend_lowest;
    logic [OUTPUT_QUADS-1:0]          pend_in;
    logic                             last;
    logic                             accept;
    logic                             out_fire;

    // Isolate the lowest pending slot; this is the one on the output.
    assign pend_lowest = pend_q & (~pend_q + OUTPUT_QUADS'(1));

    // Exactly one bit left: clearing the lowest bit leaves nothing.
    assign last = (pend_q != '0) && ((pend_q & (pend_q - OUTPUT_QUADS'(1))) == '0);

    assign valid_out = |pend_q;
    assign ready_in  = (pend_q == '0) || (ready_out && last);
    assign busy_out  = (pend_q != '0) || valid_in;

    assign accept   = valid_in && ready_in;
    assign out_fire = valid_out && ready_out;

    // pend_lowest is one-hot or zero, so at most one slot is selected and the
    // output is zero when nothing is pending.
    always_comb begin
        stamp_out = '0;
        for (int i = 0; i < OUTPUT_QUADS; i++) begin
            if (pend_lowest[i]) begin
                stamp_out = batch_q[i];
            end
        end
    end

    always_comb begin
        pend_in = '0;
        for (int i = 0; i < OUTPUT_QUADS; i++) begin
            pend_in[i] = (stamps_in[i].mask != 4'd0);
        end
    end

    // Accept only happens when the old batch is finished (or finishing this
    // cycle), so the load simply overwrites the pending bitmap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q             <= '0;
            perf_stamps_out    <= '0;
            perf_empty_batches <= '0;
        end else begin
            if (accept) begin
                pend_q <= pend_in;
            end else if (out_fire) begin
                pend_q <= pend_q & ~pend_lowest;
            end

            if (out_fire) begin
                perf_stamps_out <= perf_stamps_out + PERF_CTR_BITS'(1);
            end

            if (accept && (pend_in == '0)) begin
                perf_empty_batches <= perf_empty_batches + PERF_CTR_BITS'(1);
            end
        end
    end

    // Stamp payload storage; only meaningful where pend_q has a bit set.
    always_ff @(posedge clk) begin
        if (accept) begin
            batch_q <= stamps_in;
        end
    end

endmodule

// File: tb/tb_raster_stamp_serializer.sv
module tb_raster_stamp_serializer;
  import raster_stamp_pkg::*;

  localparam int OQ = 4;
  typedef raster_stamp_t [OQ-1:0] batch_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          valid_in;
  batch_t        stamps_in;
  logic          ready_out;

  logic          ready_in, valid_out, busy_out;
  raster_stamp_t stamp_out;
  logic [31:0]   perf_stamps_out, perf_empty_batches;

  logic          ready_in4, valid_out4, busy_out4;
  raster_stamp_t stamp_out4;
  logic [3:0]    perf_stamps_out4, perf_empty_batches4;

  raster_stamp_serializer #(.OUTPUT_QUADS(OQ), .PERF_CTR_BITS(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stamps_in(stamps_in),
    .ready_in(ready_in), .valid_out(valid_out), .stamp_out(stamp_out),
    .ready_out(ready_out), .busy_out(busy_out),
    .perf_stamps_out(perf_stamps_out), .perf_empty_batches(perf_empty_batches)
  );

  // Same stimulus, narrow counters for the wrap check.
  raster_stamp_serializer #(.OUTPUT_QUADS(OQ), .PERF_CTR_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stamps_in(stamps_in),
    .ready_in(ready_in4), .valid_out(valid_out4), .stamp_out(stamp_out4),
    .ready_out(ready_out), .busy_out(busy_out4),
    .perf_stamps_out(perf_stamps_out4), .perf_empty_batches(perf_empty_batches4)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // cur_q: stamps of the current batch still to be emitted, in order.
  // exp_q: scoreboard of every stamp expected on the output stream.
  raster_stamp_t cur_q[$];
  logic [31:0]   exp_q[$];
  logic [31:0]   m_stamps;
  logic [31:0]   m_empty;
  int            m_accepts;
  logic          m_acc;
  logic          prev_stall;
  raster_stamp_t prev_stamp;

  task automatic model_reset();
    cur_q.delete();
    exp_q.delete();
    m_stamps   = '0;
    m_empty    = '0;
    m_acc      = 1'b0;
    prev_stall = 1'b0;
    prev_stamp = '0;
  endtask

  // Called mid-cycle with inputs stable; compares, then advances the model
  // by the clock edge that follows.
  task automatic model_check();
    logic          exp_valid;
    logic          exp_ri;
    logic          exp_busy;
    logic          any;
    raster_stamp_t exp_stamp;
    exp_valid = (cur_q.size() != 0);
    exp_stamp = exp_valid ? cur_q[0] : '0;
    exp_ri    = (cur_q.size() == 0) || (ready_out && cur_q.size() == 1);
    exp_busy  = exp_valid || valid_in;

    chk("valid_out", 64'(valid_out), 64'(exp_valid));
    chk("stamp_out", 64'(stamp_out), 64'(exp_stamp));
    chk("ready_in", 64'(ready_in), 64'(exp_ri));
    chk("busy_out", 64'(busy_out), 64'(exp_busy));
    chk("perf_stamps", 64'(perf_stamps_out), 64'(m_stamps));
    chk("perf_empty", 64'(perf_empty_batches), 64'(m_empty));
    chk("valid_out4", 64'(valid_out4), 64'(exp_valid));
    chk("stamp_out4", 64'(stamp_out4), 64'(exp_stamp));
    chk("ready_in4", 64'(ready_in4), 64'(exp_ri));
    chk("busy_out4", 64'(busy_out4), 64'(exp_busy));
    chk("perf_stamps4", 64'(perf_stamps_out4), 64'(m_stamps[3:0]));
    chk("perf_empty4", 64'(perf_empty_batches4), 64'(m_empty[3:0]));

    if (prev_stall) begin
      chk("stall_valid", 64'(valid_out), 64'(1));
      chk("stall_stamp", 64'(stamp_out), 64'(prev_stamp));
    end

    if (valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: got stamp 0x%0h expected none at %0t", stamp_out, $time);
      end else begin
        chk("sb_order", 64'(stamp_out), 64'(exp_q.pop_front()));
      end
    end
    prev_stall = valid_out && !ready_out;
    prev_stamp = stamp_out;

    if (exp_valid && ready_out) begin
      void'(cur_q.pop_front());
      m_stamps = m_stamps + 32'd1;
    end
    m_acc = valid_in && exp_ri;
    if (m_acc) begin
      m_accepts++;
      any = 1'b0;
      for (int i = 0; i < OQ; i++) begin
        if (stamps_in[i].mask != 4'd0) begin
          cur_q.push_back(stamps_in[i]);
          exp_q.push_back(stamps_in[i]);
          any = 1'b1;
        end
      end
      if (!any) m_empty = m_empty + 32'd1;
    end
  endtask

  // ---------------- driver helpers ----------------
  function automatic raster_stamp_t mk_stamp(input logic [15:0] b, input int s, input logic [3:0] m);
    raster_stamp_t r;
    r.x       = 10'(int'(b) * 4 + s);
    r.y       = 10'(b) ^ 10'h2a5;
    r.prim_id = 8'(b) + 8'(s * 37);
    r.mask    = m;
    return r;
  endfunction

  function automatic batch_t build_batch(input logic [15:0] b, input logic [15:0] masks);
    batch_t r;
    for (int i = 0; i < OQ; i++) r[i] = mk_stamp(b, i, masks[4*i +: 4]);
    return r;
  endfunction

  function automatic batch_t rand_batch();
    batch_t r;
    for (int i = 0; i < OQ; i++) begin
      r[i].x       = 10'($urandom);
      r[i].y       = 10'($urandom);
      r[i].prim_id = 8'($urandom);
      r[i].mask    = ($urandom_range(0, 99) < 35) ? 4'd0 : 4'($urandom_range(1, 15));
    end
    return r;
  endfunction

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] b, input logic [15:0] masks);
    int n;
    valid_in  = 1'b1;
    stamps_in = build_batch(b, masks);
    n = 0;
    m_acc = 1'b0;
    while (!m_acc && n < 50) begin
      cycle();
      n++;
    end
    if (!m_acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL offer_timeout: batch %0d not accepted in %0d cycles", b, n);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic        r;
    logic [15:0] batch;
    logic [15:0] masks;
    logic        ev;
    logic [15:0] eb;
    logic [1:0]  es;
    logic [3:0]  em;
    logic        eri;
  } vec_t;

  vec_t vecs[21];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    raster_stamp_t es;

    // full batch, ready_out held high
    vecs[0]  = '{1'b1, 1'b1, 16'd1, 16'hFFFF, 1'b0, 16'd0, 2'd0, 4'h0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 16'd1, 16'hFFFF, 1'b1, 16'd1, 2'd0, 4'hF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'd1, 16'hFFFF, 1'b1, 16'd1, 2'd1, 4'hF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'd1, 16'hFFFF, 1'b1, 16'd1, 2'd2, 4'hF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'd1, 16'hFFFF, 1'b1, 16'd1, 2'd3, 4'hF, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 16'd1, 16'hFFFF, 1'b0, 16'd0, 2'd0, 4'h0, 1'b1};
    // squash and order: masks {0,3,0,8}, then an all-empty batch
    vecs[6]  = '{1'b1, 1'b1, 16'd2, 16'h8030, 1'b0, 16'd0, 2'd0, 4'h0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 16'd2, 16'h8030, 1'b1, 16'd2, 2'd1, 4'h3, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'd2, 16'h8030, 1'b1, 16'd2, 2'd3, 4'h8, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 16'd3, 16'h0000, 1'b0, 16'd0, 2'd0, 4'h0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 16'd3, 16'h0000, 1'b0, 16'd0, 2'd0, 4'h0, 1'b1};
    // back-to-back batches, valid_in held high
    vecs[11] = '{1'b1, 1'b1, 16'd4, 16'hFFFF, 1'b0, 16'd0, 2'd0, 4'h0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd4, 2'd0, 4'hF, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd4, 2'd1, 4'hF, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd4, 2'd2, 4'hF, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd4, 2'd3, 4'hF, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd5, 2'd0, 4'hF, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd5, 2'd1, 4'hF, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd5, 2'd2, 4'hF, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 16'd5, 16'hFFFF, 1'b1, 16'd5, 2'd3, 4'hF, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 16'd5, 16'hFFFF, 1'b0, 16'd0, 2'd0, 4'h0, 1'b1};

    // ---- reset ----
    model_reset();
    m_accepts = 0;
    reset     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    stamps_in = '0;
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_ready_in", 64'(ready_in), 64'(1));
    chk("rst_busy_out", 64'(busy_out), 64'(0));
    chk("rst_perf_stamps", 64'(perf_stamps_out), 64'(0));
    chk("rst_perf_empty", 64'(perf_empty_batches), 64'(0));
    #21;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 21; i++) begin
      valid_in  = vecs[i].v;
      ready_out = vecs[i].r;
      stamps_in = build_batch(vecs[i].batch, vecs[i].masks);
      @(negedge clk);
      es = vecs[i].ev ? mk_stamp(vecs[i].eb, int'(vecs[i].es), vecs[i].em) : '0;
      chk($sformatf("vec%0d_valid_out", i), 64'(valid_out), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_stamp_out", i), 64'(stamp_out), 64'(es));
      chk($sformatf("vec%0d_ready_in", i), 64'(ready_in), 64'(vecs[i].eri));
      chk($sformatf("vec%0d_busy_out", i), 64'(busy_out), 64'(vecs[i].ev || vecs[i].v));
      model_check();
      @(posedge clk);
      #1;
    end
    chk("table_perf_stamps", 64'(perf_stamps_out), 64'(14));
    chk("table_perf_empty", 64'(perf_empty_batches), 64'(1));

    // ---- randomized traffic with 30% output stalls ----
    begin
      int start_acc;
      int cyc;
      start_acc = m_accepts;
      valid_in  = 1'b0;
      cyc = 0;
      while ((m_accepts - start_acc) < 1000 && cyc < 20000) begin
        if (!valid_in || m_acc) begin
          valid_in  = ($urandom_range(0, 99) < 75);
          stamps_in = rand_batch();
        end
        ready_out = ($urandom_range(0, 99) >= 30);
        cycle();
        cyc++;
      end
      if ((m_accepts - start_acc) < 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL random_budget: got %0d batches expected 1000", m_accepts - start_acc);
      end
      valid_in  = 1'b0;
      ready_out = 1'b1;
      for (int i = 0; i < 8; i++) cycle();
      chk("random_leftover", 64'(exp_q.size()), 64'(0));
    end

    // ---- asynchronous reset in the middle of a batch (pend = 1010) ----
    ready_out = 1'b0;
    offer(16'd20, 16'hF0F0);
    valid_in = 1'b0;
    cycle();
    chk("pre_rst_stamp", 64'(stamp_out), 64'(mk_stamp(16'd20, 1, 4'hF)));
    valid_in  = 1'b1;
    stamps_in = build_batch(16'd21, 16'hFFFF);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid_out", 64'(valid_out), 64'(0));
    chk("mid_rst_stamp_out", 64'(stamp_out), 64'(0));
    chk("mid_rst_ready_in", 64'(ready_in), 64'(1));
    chk("mid_rst_busy_hi", 64'(busy_out), 64'(1));
    chk("mid_rst_perf_stamps", 64'(perf_stamps_out), 64'(0));
    chk("mid_rst_perf_empty", 64'(perf_empty_batches), 64'(0));
    chk("mid_rst_perf_stamps4", 64'(perf_stamps_out4), 64'(0));
    valid_in = 1'b0;
    #1;
    chk("mid_rst_busy_lo", 64'(busy_out), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("post_rst_no_stamp", 64'(perf_stamps_out), 64'(0));

    // ---- counter wrap: 17 stamps on a 4-bit counter ----
    offer(16'd30, 16'hFFFF);
    offer(16'd31, 16'hFFFF);
    offer(16'd32, 16'hFFFF);
    offer(16'd33, 16'hFFFF);
    offer(16'd34, 16'h0001);
    valid_in = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("wrap_perf_stamps4", 64'(perf_stamps_out4), 64'(1));
    chk("wrap_perf_stamps32", 64'(perf_stamps_out), 64'(17));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_stamp_serializer.md
Name: raster_stamp_serializer

Overview:
- Sits directly downstream of the raster slice and consumes its batch output: one valid plus OUTPUT_QUADS raster_stamp_t per handshake.
- Emits the covered stamps one per cycle on a single-stamp valid/ready stream toward the raster unit's per-core arbiter.
- Stamps with an all-zero coverage mask are squashed. A batch with no covered stamps is dropped.
- Provides a busy flag and two wrap-around performance counters.

Parameters:
- OUTPUT_QUADS, 4, stamps per input batch; must be ≥1 and match the slice's OUTPUT_QUADS.
- PERF_CTR_BITS, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  input batch valid.
- stamps_in  in  OUTPUT_QUADS x $bits(raster_stamp_t)  input batch; slot i uses stamps_in[i].mask (4 bits) as its coverage mask.
- ready_in  out  1  batch accepted when valid_in && ready_in.
- valid_out  out  1  output stamp valid.
- stamp_out  out  $bits(raster_stamp_t)  current output stamp, a bit-exact copy of the stored slot.
- ready_out  in  1  output stamp consumed when valid_out && ready_out.
- busy_out  out  1  stamps pending, or a batch offered at the input.
- perf_stamps_out  out  PERF_CTR_BITS  count of emitted stamps.
- perf_empty_batches  out  PERF_CTR_BITS  count of accepted batches with no covered stamp.

Behaviour:
- Storage:
  - batch_q: OUTPUT_QUADS stamp registers, no reset needed.
  - pend_q: OUTPUT_QUADS-bit pending bitmap, reset to 0.
  - Two counters, reset to 0.
- Reset: while reset is low, asynchronously:
  - pend_q=0, counters=0.
  - Therefore valid_out=0, ready_in=1, busy_out=valid_in.
  - Asserting reset mid-batch discards all pending stamps. No stamp is emitted after release until a new batch is accepted.
- Output selection (combinational from registers):
  - sel = index of the lowest set bit of pend_q.
  - valid_out = |pend_q.
  - stamp_out = batch_q[sel]; stamp_out is 0 when pend_q == 0.
  - Order within a batch is strictly ascending slot index.
- last = pend_q is one-hot (exactly one bit set).
- ready_in = (pend_q == 0) || (ready_out && last). This is a combinational path from ready_out to ready_in and is intentional: it gives zero-bubble back-to-back batches.
- On batch accept:
  - batch_q <= stamps_in.
  - pend_q <= {stamps_in[i].mask != 0 for each i}.
- On output handshake without accept: pend_q[sel] cleared.
- Accept and final handshake in the same cycle: the new batch load wins, since the last bit is consumed.
- Latency: batch accepted at cycle N → first stamp valid at cycle N+1.
- Throughput: 1 stamp/cycle sustained, including across batch boundaries.
- All-empty batch:
  - Accepted in one cycle, pend_q stays 0, nothing emitted.
  - perf_empty_batches += 1.
  - ready_in is high again the next cycle.
- Holding valid_out:
  - valid_out is never deasserted, and stamp_out never changes, while ready_out is low.
  - The input is not sampled while pend_q has ≥2 bits set, or one bit set with ready_out low.
- perf_stamps_out += 1 per output handshake. Both counters wrap at 2^PERF_CTR_BITS with no saturation.
- busy_out = (pend_q != 0) || valid_in. The parent ORs this into its own busy.
- OUTPUT_QUADS = 1: degenerates to a squashing pipeline register at the same 1 stamp/cycle throughput.

Test Plan:
- Reset/idle: reset low mid-batch with pend_q=4'b1010 → valid_out=0 within the same cycle, ready_in=1, counters=0; after release, no stamp appears without a new batch.
- Single full batch, ready_out held 1: masks {F,F,F,F} at cycle 0 → stamps 0,1,2,3 on cycles 1–4; ready_in=0 on cycles 1–3 and 1 on cycle 4; perf_stamps_out=4.
- Squash and order: masks {0,3,0,8} → exactly two output stamps, slot 1 then slot 3, bit-exact; then masks {0,0,0,0} → no output, perf_empty_batches=1, ready_in=1 the following cycle.
- Back-to-back batches: two batches of 4 covered stamps with valid_in held high and ready_out=1 → 8 stamps on 8 consecutive cycles with no bubble; the second batch is accepted on the cycle the 4th stamp handshakes.
- Backpressure: random ready_out at 30% → valid_out never drops and stamp_out is stable while stalled; no loss or duplication over 1000 random batches checked against a scoreboard.
- Counter wrap: with PERF_CTR_BITS=4, emit 17 stamps → perf_stamps_out=1.
